// File: rtl/rfphoenix_ictag_lru.sv
// Instruction-cache tag store with valid bits, victim selection and a line-by-line flush sweep.
// Define ICTAG_PLRU_EN for tree pseudo-LRU replacement; the default build uses a round-robin pointer per index.
module rfphoenix_ictag_lru #(
    parameter int LINES = 128,
    parameter int WAYS  = 4,
    parameter int AWID  = 32,
    parameter int LOBIT = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_v,
    input  logic [AWID-1:0]          req_adr,
    output logic                     hit,
    output logic [$clog2(WAYS)-1:0]  hit_way,
    output logic                     rd_v,
    input  logic                     wr,
    input  logic [AWID-1:0]          wr_adr,
    output logic [$clog2(WAYS)-1:0]  victim_way,
    input  logic                     inv_line,
    input  logic [AWID-1:0]          inv_adr,
    input  logic                     inv_all,
    output logic                     busy
);

    localparam int IW = $clog2(LINES);
    localparam int WW = $clog2(WAYS);
    localparam int TW = AWID - LOBIT;
`ifdef ICTAG_PLRU_EN
    localparam int RW = WAYS - 1;
`else
    localparam int RW = WW;
`endif

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SWEEP = 1'b1;

    logic [TW-1:0]   tag_mem  [WAYS][LINES];
    logic [WAYS-1:0] vld_mem  [LINES];
    logic [RW-1:0]   repl_mem [LINES];

    logic [0:0]      state_q;
    logic [IW-1:0]   sweep_cnt;

    logic            req_vld_p0;
    logic [IW-1:0]   req_idx_p0;
    logic [TW-1:0]   req_tag_p0;

    logic [IW-1:0]   wr_idx;
    logic [TW-1:0]   wr_tag;
    logic [IW-1:0]   inv_idx;
    logic [TW-1:0]   inv_tag;

    logic [WAYS-1:0] rd_match;
    logic [WAYS-1:0] inv_match;
    logic [WAYS-1:0] wr_vld;
    logic            fill_en;
    logic            inv_en;
    logic            hit_upd;
    logic            unused_lo;

    function automatic logic [WW-1:0] lowest_way(input logic [WAYS-1:0] v);
        logic [WW-1:0] w_sel;
        w_sel = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (v[w]) w_sel = WW'(w);
        end
        return w_sel;
    endfunction

`ifdef ICTAG_PLRU_EN
    // Heap-ordered tree, node n at bit n-1; a set bit means the right subtree is the older one.
    function automatic logic [WW-1:0] plru_victim(input logic [RW-1:0] t);
        int n;
        n = 1;
        for (int l = 0; l < WW; l++) begin
            n = 2 * n + (t[n-1] ? 1 : 0);
        end
        return WW'(n - WAYS);
    endfunction

    function automatic logic [RW-1:0] plru_touch(input logic [RW-1:0] t, input logic [WW-1:0] w);
        logic [RW-1:0] r;
        logic          b;
        int            n;
        r = t;
        n = 1;
        for (int l = 0; l < WW; l++) begin
            b      = w[WW-1-l];
            r[n-1] = ~b;
            n      = 2 * n + (b ? 1 : 0);
        end
        return r;
    endfunction
`endif

    assign wr_idx    = wr_adr[LOBIT+IW-1:LOBIT];
    assign wr_tag    = wr_adr[AWID-1:LOBIT];
    assign inv_idx   = inv_adr[LOBIT+IW-1:LOBIT];
    assign inv_tag   = inv_adr[AWID-1:LOBIT];
    assign unused_lo = ^{req_adr[LOBIT-1:0], wr_adr[LOBIT-1:0], inv_adr[LOBIT-1:0]};

    assign busy    = (state_q == SWEEP);
    assign fill_en = wr & ~busy;
    assign inv_en  = inv_line & ~busy & ~(wr && (wr_idx == inv_idx));

    // Stage p0: lookup request registered; arrays are read combinationally in the following cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_vld_p0 <= 1'b0;
        end else begin
            req_vld_p0 <= req_v;
        end
    end

    always_ff @(posedge clk) begin
        req_idx_p0 <= req_adr[LOBIT+IW-1:LOBIT];
        req_tag_p0 <= req_adr[AWID-1:LOBIT];
    end

    always_comb begin
        rd_match  = '0;
        inv_match = '0;
        for (int w = 0; w < WAYS; w++) begin
            rd_match[w]  = vld_mem[req_idx_p0][w] && (tag_mem[w][req_idx_p0] == req_tag_p0);
            inv_match[w] = vld_mem[inv_idx][w] && (tag_mem[w][inv_idx] == inv_tag);
        end
    end

    assign rd_v    = req_vld_p0;
    assign hit     = req_vld_p0 & ~busy & (|rd_match);
    assign hit_way = hit ? lowest_way(rd_match) : '0;
    assign hit_upd = hit & ~(fill_en && (wr_idx == req_idx_p0));

    assign wr_vld = vld_mem[wr_idx];
    always_comb begin
        if (!(&wr_vld)) begin
            victim_way = lowest_way(~wr_vld);
        end else begin
`ifdef ICTAG_PLRU_EN
            victim_way = plru_victim(repl_mem[wr_idx]);
`else
            victim_way = repl_mem[wr_idx];
`endif
        end
    end

    // Flush sequencer: one index cleared per cycle while sweeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sweep_cnt <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (inv_all) begin
                        state_q   <= SWEEP;
                        sweep_cnt <= '0;
                    end
                end
                SWEEP: begin
                    if (sweep_cnt == IW'(LINES - 1)) begin
                        state_q   <= IDLE;
                        sweep_cnt <= '0;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    sweep_cnt <= '0;
                end
            endcase
        end
    end

    // A fill and an invalidate can only both land here when they target different indices.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LINES; i++) vld_mem[i] <= '0;
        end else if (busy) begin
            vld_mem[sweep_cnt] <= '0;
        end else begin
            if (fill_en) vld_mem[wr_idx][victim_way] <= 1'b1;
            if (inv_en)  vld_mem[inv_idx] <= vld_mem[inv_idx] & ~inv_match;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LINES; i++) repl_mem[i] <= '0;
        end else if (busy) begin
            repl_mem[sweep_cnt] <= '0;
        end else begin
`ifdef ICTAG_PLRU_EN
            if (hit_upd) repl_mem[req_idx_p0] <= plru_touch(repl_mem[req_idx_p0], hit_way);
            if (fill_en) repl_mem[wr_idx]     <= plru_touch(repl_mem[wr_idx], victim_way);
`else
            if (fill_en) repl_mem[wr_idx] <= repl_mem[wr_idx] + 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) tag_mem[victim_way][wr_idx] <= wr_tag;
    end

`ifndef ICTAG_PLRU_EN
    logic unused_hit_upd;
    assign unused_hit_upd = hit_upd;
`endif

endmodule

// File: tb/tb_rfphoenix_ictag_lru.sv
// Bench for rfphoenix_ictag_lru: directed scenarios plus random traffic against a behavioural cache model.
module tb_rfphoenix_ictag_lru;

    localparam int LINES = 128;
    localparam int WAYS  = 4;
    localparam int AWID  = 32;
    localparam int LOBIT = 6;
    localparam int IW    = $clog2(LINES);
    localparam int WW    = $clog2(WAYS);

    logic            clk;
    logic            rst;
    logic            req_v;
    logic [AWID-1:0] req_adr;
    logic            hit;
    logic [WW-1:0]   hit_way;
    logic            rd_v;
    logic            wr;
    logic [AWID-1:0] wr_adr;
    logic [WW-1:0]   victim_way;
    logic            inv_line;
    logic [AWID-1:0] inv_adr;
    logic            inv_all;
    logic            busy;

    int n_chk  = 0;
    int n_fail = 0;

    rfphoenix_ictag_lru #(.LINES(LINES), .WAYS(WAYS), .AWID(AWID), .LOBIT(LOBIT)) dut (
        .clk(clk), .rst(rst),
        .req_v(req_v), .req_adr(req_adr),
        .hit(hit), .hit_way(hit_way), .rd_v(rd_v),
        .wr(wr), .wr_adr(wr_adr), .victim_way(victim_way),
        .inv_line(inv_line), .inv_adr(inv_adr), .inv_all(inv_all),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: plain per-way/per-index arrays.
    logic [AWID-1:0] m_tag  [WAYS][LINES];
    bit              m_val  [WAYS][LINES];
    int              m_fills[LINES];
    bit [WAYS-1:0]   m_tree [LINES];
    bit              m_busy;
    int              m_cnt;
    bit              m_pv;
    int              m_pidx;
    logic [AWID-1:0] m_ptag;

    function automatic int idx_of(input logic [AWID-1:0] a);
        return int'((a >> LOBIT) % LINES);
    endfunction

    function automatic logic [AWID-1:0] tag_of(input logic [AWID-1:0] a);
        return a >> LOBIT;
    endfunction

    function automatic logic [AWID-1:0] mk(input int t, input int i, input int off);
        return (AWID'(t) << (LOBIT + IW)) | (AWID'(i) << LOBIT) | AWID'(off);
    endfunction

    function automatic int m_find(input int idx, input logic [AWID-1:0] t);
        for (int w = 0; w < WAYS; w++)
            if (m_val[w][idx] && m_tag[w][idx] == t) return w;
        return -1;
    endfunction

    function automatic int m_plru_victim(input int idx);
        int lo, hi, node, mid;
        lo = 0; hi = WAYS; node = 1;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (m_tree[idx][node]) begin lo = mid; node = 2 * node + 1; end
            else begin hi = mid; node = 2 * node; end
        end
        return lo;
    endfunction

    task automatic m_plru_touch(input int idx, input int w);
        int lo, hi, node, mid;
        lo = 0; hi = WAYS; node = 1;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            m_tree[idx][node] = (w < mid);
            if (w < mid) begin hi = mid; node = 2 * node; end
            else begin lo = mid; node = 2 * node + 1; end
        end
    endtask

    function automatic int m_victim(input int idx);
        for (int w = 0; w < WAYS; w++)
            if (!m_val[w][idx]) return w;
`ifdef ICTAG_PLRU_EN
        return m_plru_victim(idx);
`else
        return m_fills[idx] % WAYS;
`endif
    endfunction

    task automatic m_reset();
        for (int i = 0; i < LINES; i++) begin
            for (int w = 0; w < WAYS; w++) m_val[w][i] = 1'b0;
            m_fills[i] = 0;
            m_tree[i]  = '0;
        end
        m_busy = 1'b0; m_cnt = 0; m_pv = 1'b0; m_pidx = 0; m_ptag = '0;
    endtask

    always @(posedge clk or negedge rst) begin
        int hw, wi, ii, vw;
        bit hv, fv, ie;
        if (!rst) begin
            m_reset();
        end else begin
            hw = m_pv ? m_find(m_pidx, m_ptag) : -1;
            hv = m_pv && !m_busy && (hw >= 0);
            wi = idx_of(wr_adr);
            ii = idx_of(inv_adr);
            fv = wr && !m_busy;
            ie = inv_line && !m_busy && !(wr && wi == ii);
            vw = m_victim(wi);
            if (m_busy) begin
                for (int w = 0; w < WAYS; w++) m_val[w][m_cnt] = 1'b0;
                m_fills[m_cnt] = 0;
                m_tree[m_cnt]  = '0;
                m_cnt++;
                if (m_cnt == LINES) begin m_busy = 1'b0; m_cnt = 0; end
            end else begin
                if (ie)
                    for (int w = 0; w < WAYS; w++)
                        if (m_val[w][ii] && m_tag[w][ii] == tag_of(inv_adr)) m_val[w][ii] = 1'b0;
`ifdef ICTAG_PLRU_EN
                if (hv && !(fv && wi == m_pidx)) m_plru_touch(m_pidx, hw);
`endif
                if (fv) begin
                    m_tag[vw][wi] = tag_of(wr_adr);
                    m_val[vw][wi] = 1'b1;
                    m_fills[wi]++;
                    m_plru_touch(wi, vw);
                end
                if (inv_all) begin m_busy = 1'b1; m_cnt = 0; end
            end
            m_pv   = req_v;
            m_pidx = idx_of(req_adr);
            m_ptag = tag_of(req_adr);
        end
    end

    // Cycle-by-cycle comparison on the inactive edge.
    always @(negedge clk) begin
        int fw;
        bit eh;
        fw = m_pv ? m_find(m_pidx, m_ptag) : -1;
        eh = m_pv && !m_busy && (fw >= 0);
        chk("rd_v", 32'(rd_v), 32'(m_pv));
        chk("hit", 32'(hit), 32'(eh));
        chk("hit_way", 32'(hit_way), eh ? 32'(fw) : 32'd0);
        chk("busy", 32'(busy), 32'(m_busy));
        chk("victim_way", 32'(victim_way), 32'(m_victim(idx_of(wr_adr))));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [AWID-1:0] a);
        req_v = 1'b1; req_adr = a;
        step();
        req_v = 1'b0;
    endtask

    task automatic count_sweep(input string nm);
        int n;
        n = 0;
        while (busy && n < 1000) begin
            wr = 1'b1; wr_adr = mk(7, n % LINES, 0);
            step();
            n++;
        end
        wr = 1'b0;
        chk(nm, 32'(n), 32'(LINES));
    endtask

    initial begin
        rst = 1'b0; req_v = 1'b0; req_adr = '0; wr = 1'b0; wr_adr = '0;
        inv_line = 1'b0; inv_adr = '0; inv_all = 1'b0;
        repeat (3) step();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rd_v", 32'(rd_v), 32'd0);
        rst = 1'b1;

        // Empty cache lookup.
        wr_adr = 32'h0000_1040;
        lookup(32'h0000_1040);
        chk("empty_rd_v", 32'(rd_v), 32'd1);
        chk("empty_hit", 32'(hit), 32'd0);
        chk("empty_victim", 32'(victim_way), 32'd0);

        // Four fills into one index take ways 0..3.
        for (int k = 0; k < 4; k++) begin
            wr = 1'b1; wr_adr = 32'h0000_1040 + (32'(k) << 16);
            #1;
            chk("fill_victim", 32'(victim_way), 32'(k));
            step();
        end
        wr = 1'b0;
        lookup(32'h0002_1040);
        chk("hit_w2", 32'(hit), 32'd1);
        chk("hit_w2_way", 32'(hit_way), 32'd2);

        // Hits on ways 0,1,2 then victim query.
        lookup(32'h0000_1040);
        lookup(32'h0001_1040);
        lookup(32'h0002_1040);
        step();
        wr_adr = 32'h0004_1040;
        #1;
`ifndef ICTAG_PLRU_EN
        chk("rr_victim", 32'(victim_way), 32'd0);
`endif

        // Single-line invalidate, then fill racing an invalidate on the same index.
        inv_line = 1'b1; inv_adr = 32'h0001_1040;
        step();
        inv_line = 1'b0;
        lookup(32'h0001_1040);
        chk("inv_miss", 32'(hit), 32'd0);
        wr = 1'b1; wr_adr = 32'h0005_1040; inv_line = 1'b1; inv_adr = 32'h0000_1040;
        #1;
        chk("refill_victim", 32'(victim_way), 32'd1);
        step();
        wr = 1'b0; inv_line = 1'b0;
        lookup(32'h0005_1040);
        chk("race_fill_hit", 32'(hit), 32'd1);
        chk("race_fill_way", 32'(hit_way), 32'd1);
        lookup(32'h0000_1040);
        chk("race_keep_hit", 32'(hit), 32'd1);
        chk("race_keep_way", 32'(hit_way), 32'd0);

        // Full flush; fills issued while busy must be dropped.
        inv_all = 1'b1;
        step();
        inv_all = 1'b0;
        count_sweep("sweep_len");
        lookup(32'h0000_1040);
        chk("flush_miss0", 32'(hit), 32'd0);
        lookup(32'h0002_1040);
        chk("flush_miss2", 32'(hit), 32'd0);
        lookup(mk(7, 3, 0));
        chk("busy_wr_dropped", 32'(hit), 32'd0);

        // Reset in the middle of a sweep.
        wr = 1'b1; wr_adr = 32'h0000_1040;
        step();
        wr = 1'b0;
        inv_all = 1'b1;
        step();
        inv_all = 1'b0;
        repeat (40) step();
        chk("mid_sweep_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        req_v = 1'b1; req_adr = 32'h0000_1040;
        step();
        chk("reset_req_ignored", 32'(rd_v), 32'd0);
        step();
        req_v = 1'b0;
        rst = 1'b1;
        lookup(32'h0000_1040);
        chk("post_reset_miss", 32'(hit), 32'd0);
        inv_all = 1'b1;
        step();
        inv_all = 1'b0;
        count_sweep("resweep_len");

        // Random traffic over a few indices and tags.
        for (int c = 0; c < 3000; c++) begin
            int idxs[4];
            idxs = '{0, 1, 2, LINES - 1};
            req_v    = ($urandom % 2) == 1;
            req_adr  = mk($urandom % 6, idxs[$urandom % 4], $urandom % 64);
            wr       = ($urandom % 10) < 3;
            wr_adr   = mk($urandom % 6, idxs[$urandom % 4], $urandom % 64);
            inv_line = ($urandom % 10) == 0;
            inv_adr  = mk($urandom % 6, idxs[$urandom % 4], 0);
            inv_all  = ($urandom % 400) == 0;
            step();
        end
        req_v = 1'b0; wr = 1'b0; inv_line = 1'b0; inv_all = 1'b0;
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
